// File: rtl/frame_err_injector.sv
// -----------------------------------------------------------------------------
// frame_err_injector
//
// Error-insertion stage that sits between the payload mapper and the line
// output. Framed data passes through with one cycle of latency. While the
// injector is armed, a mask is XORed into selected beats. Which beats are
// corrupted depends on a programmable mode: single-shot, periodic, burst or
// once per frame. Corrupted beats are counted so the receiver's error
// detection can be checked against a known number.
//
// Ports
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_row_cnt, i_col_cnt               frame position of the input beat
//   i_pyld_data, i_pyld_data_valid     input beat and its valid flag
//   i_frame_data_fas                   input beat is a frame-alignment byte
//   o_frame_data(_valid/_fas)          registered output beat, possibly
//                                      corrupted
//   i_corrupt_en                       master enable; arms the injector
//   i_corrupt_mode                     0 SINGLE, 1 PERIODIC, 2 BURST,
//                                      3 PER_FRAME
//   i_corrupt_mask                     XOR mask; 0 selects the LFSR mask
//   i_period, i_burst_len              PERIODIC interval, BURST length
//   i_tgt_row, i_tgt_col               target position (SINGLE/BURST/PER_FRAME)
//   i_fas_corrupt_en                   allow FAS beats to be corrupted
//   o_err_cnt                          saturating count of corrupted beats
//   o_busy                             injector state is not IDLE
// -----------------------------------------------------------------------------
module frame_err_injector #(
  parameter int DATA_W  = 8,   // must not exceed the 16-bit LFSR width
  parameter int ROW_W   = 2,
  parameter int COL_W   = 11,
  parameter int PER_W   = 16,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ROW_W-1:0]   i_row_cnt,
  input  logic [COL_W-1:0]   i_col_cnt,
  input  logic [DATA_W-1:0]  i_pyld_data,
  input  logic               i_pyld_data_valid,
  input  logic               i_frame_data_fas,
  output logic [DATA_W-1:0]  o_frame_data,
  output logic               o_frame_data_valid,
  output logic               o_frame_data_fas,
  input  logic               i_corrupt_en,
  input  logic [1:0]         i_corrupt_mode,
  input  logic [DATA_W-1:0]  i_corrupt_mask,
  input  logic [PER_W-1:0]   i_period,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic [ROW_W-1:0]   i_tgt_row,
  input  logic [COL_W-1:0]   i_tgt_col,
  input  logic               i_fas_corrupt_en,
  output logic [CNT_W-1:0]   o_err_cnt,
  output logic               o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_BURST, ST_DONE} state_t;

  localparam logic [1:0]         MODE_SINGLE   = 2'd0;
  localparam logic [1:0]         MODE_PERIODIC = 2'd1;
  localparam logic [1:0]         MODE_BURST    = 2'd2;
  localparam logic [PER_W-1:0]   PER_ONE       = 1;
  localparam logic [BURST_W-1:0] BURST_ONE     = 1;
  localparam logic [DATA_W-1:0]  DATA_ONE      = 1;
  localparam logic [15:0]        LFSR_SEED     = 16'hACE1;

  state_t               state_reg, state_next;
  logic [1:0]           mode_reg;
  logic [PER_W-1:0]     period_reg;
  logic [BURST_W-1:0]   burst_len_reg;
  logic [ROW_W-1:0]     tgt_row_reg;
  logic [COL_W-1:0]     tgt_col_reg;
  logic [DATA_W-1:0]    mask_reg;
  logic [PER_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [BURST_W-1:0]   remaining_reg, remaining_next;
  logic [15:0]          lfsr_reg, lfsr_next;

  logic                 eligible;
  logic                 pos_hit;
  logic                 hit;
  logic                 latch_cfg;
  logic [PER_W-1:0]     period_last;
  logic [DATA_W-1:0]    mask;
  logic [DATA_W-1:0]    data_next;

  // FAS beats are invisible to the injector unless explicitly allowed.
  assign eligible = i_pyld_data_valid & (~i_frame_data_fas | i_fas_corrupt_en);
  assign pos_hit  = eligible & (i_row_cnt == tgt_row_reg) & (i_col_cnt == tgt_col_reg);

  // A period of 0 behaves like 1: every eligible beat is hit.
  assign period_last = (period_reg == '0) ? '0 : (period_reg - PER_ONE);

  // Forcing bit 0 keeps the LFSR-derived mask from ever being zero.
  assign mask = (mask_reg != '0) ? mask_reg : (lfsr_reg[DATA_W-1:0] | DATA_ONE);

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form.
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_xor
      assign data_next[gi] = i_pyld_data[gi] ^ (hit & mask[gi]);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    remaining_next = remaining_reg;
    hit            = 1'b0;
    latch_cfg      = 1'b0;
    // Dropping the enable wins over everything, including a burst in flight.
    if (!i_corrupt_en) begin
      state_next     = ST_IDLE;
      beat_cnt_next  = '0;
      remaining_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next     = ST_ARMED;
          latch_cfg      = 1'b1;
          beat_cnt_next  = '0;
          remaining_next = '0;
        end
        ST_ARMED: begin
          case (mode_reg)
            MODE_SINGLE: begin
              if (pos_hit) begin
                hit        = 1'b1;
                state_next = ST_DONE;
              end
            end
            MODE_PERIODIC: begin
              if (eligible) begin
                if (beat_cnt_reg == period_last) begin
                  hit           = 1'b1;
                  beat_cnt_next = '0;
                end else begin
                  beat_cnt_next = beat_cnt_reg + PER_ONE;
                end
              end
            end
            MODE_BURST: begin
              if (pos_hit) begin
                hit = 1'b1;
                if (burst_len_reg <= BURST_ONE) begin
                  state_next = ST_DONE;
                end else begin
                  state_next     = ST_BURST;
                  remaining_next = burst_len_reg - BURST_ONE;
                end
              end
            end
            default: begin
              // PER_FRAME: the target position occurs once per frame.
              hit = pos_hit;
            end
          endcase
        end
        ST_BURST: begin
          if (eligible) begin
            hit            = 1'b1;
            remaining_next = remaining_reg - BURST_ONE;
            if (remaining_reg == BURST_ONE) begin
              state_next = ST_DONE;
            end
          end
        end
        default: begin
          // DONE: hold until the enable drops.
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg          <= ST_IDLE;
      mode_reg           <= '0;
      period_reg         <= '0;
      burst_len_reg      <= '0;
      tgt_row_reg        <= '0;
      tgt_col_reg        <= '0;
      mask_reg           <= '0;
      beat_cnt_reg       <= '0;
      remaining_reg      <= '0;
      lfsr_reg           <= LFSR_SEED;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_err_cnt          <= '0;
      o_busy             <= 1'b0;
    end else begin
      state_reg          <= state_next;
      beat_cnt_reg       <= beat_cnt_next;
      remaining_reg      <= remaining_next;
      o_frame_data       <= data_next;
      o_frame_data_valid <= i_pyld_data_valid;
      o_frame_data_fas   <= i_frame_data_fas;
      o_busy             <= (state_next != ST_IDLE);
      if (latch_cfg) begin
        mode_reg      <= i_corrupt_mode;
        period_reg    <= i_period;
        burst_len_reg <= i_burst_len;
        tgt_row_reg   <= i_tgt_row;
        tgt_col_reg   <= i_tgt_col;
        mask_reg      <= i_corrupt_mask;
      end
      if (eligible) begin
        lfsr_reg <= lfsr_next;
      end
      if (hit && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_err_injector.sv
// -----------------------------------------------------------------------------
// tb_frame_err_injector
//
// Scoreboard bench for frame_err_injector. Each driven beat pushes its
// expected output beat into a queue. One cycle later, the bench pops that
// entry and compares it with the DUT output. The bench works out which beats
// should be hit from each scenario's setup and keeps its own LFSR. It also
// keeps its own count of expected errors.
// -----------------------------------------------------------------------------
module tb_frame_err_injector;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_row_cnt;
  logic [10:0] i_col_cnt;
  logic [7:0]  i_pyld_data;
  logic        i_pyld_data_valid;
  logic        i_frame_data_fas;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic        i_corrupt_en;
  logic [1:0]  i_corrupt_mode;
  logic [7:0]  i_corrupt_mask;
  logic [15:0] i_period;
  logic [7:0]  i_burst_len;
  logic [1:0]  i_tgt_row;
  logic [10:0] i_tgt_col;
  logic        i_fas_corrupt_en;
  logic [15:0] o_err_cnt;
  logic        o_busy;

  always #5 clk = ~clk;

  frame_err_injector dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_row_cnt          (i_row_cnt),
    .i_col_cnt          (i_col_cnt),
    .i_pyld_data        (i_pyld_data),
    .i_pyld_data_valid  (i_pyld_data_valid),
    .i_frame_data_fas   (i_frame_data_fas),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .i_corrupt_en       (i_corrupt_en),
    .i_corrupt_mode     (i_corrupt_mode),
    .i_corrupt_mask     (i_corrupt_mask),
    .i_period           (i_period),
    .i_burst_len        (i_burst_len),
    .i_tgt_row          (i_tgt_row),
    .i_tgt_col          (i_tgt_col),
    .i_fas_corrupt_en   (i_fas_corrupt_en),
    .o_err_cnt          (o_err_cnt),
    .o_busy             (o_busy)
  );

  typedef struct packed {
    logic [1:0]  row;
    logic [10:0] col;
    logic [7:0]  data_in;
    logic [7:0]  data;
    logic        valid;
    logic        fas;
  } exp_beat_t;

  exp_beat_t   exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          exp_err      = 0;
  logic [15:0] tb_lfsr      = 16'hACE1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1; taps 16,14,13,11 map to bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Drive one beat and record what must come out one cycle later.
  // mask == 0 means the LFSR-derived mask is expected.
  task automatic apply_beat(input logic [1:0] row, input logic [10:0] col, input logic [7:0] data,
                            input logic valid, input logic fas, input logic hit, input logic [7:0] mask);
    exp_beat_t  e;
    logic [7:0] m;
    i_row_cnt         = row;
    i_col_cnt         = col;
    i_pyld_data       = data;
    i_pyld_data_valid = valid;
    i_frame_data_fas  = fas;
    m = (mask != 8'h00) ? mask : (tb_lfsr[7:0] | 8'h01);
    e.row     = row;
    e.col     = col;
    e.data_in = data;
    e.data    = hit ? (data ^ m) : data;
    e.valid   = valid;
    e.fas     = fas;
    exp_q.push_back(e);
    if (hit) exp_err++;
    if (valid && (!fas || i_fas_corrupt_en)) tb_lfsr = lfsr_step(tb_lfsr);
  endtask

  task automatic collect_beat();
    exp_beat_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      $display("[TB] beat r%0d c%0d v%0d f%0d in=%h out=%h exp=%h", e.row, e.col, e.valid, e.fas,
               e.data_in, o_frame_data, e.data);
      check("data", o_frame_data, e.data);
      check("valid", o_frame_data_valid, e.valid);
      check("fas", o_frame_data_fas, e.fas);
    end
  endtask

  task automatic drive_beat(input logic [1:0] row, input logic [10:0] col, input logic [7:0] data,
                            input logic valid, input logic fas, input logic hit, input logic [7:0] mask);
    @(negedge clk);
    apply_beat(row, col, data, valid, fas, hit, mask);
    collect_beat();
  endtask

  task automatic idle_beat();
    drive_beat(2'd0, 11'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
  endtask

  // Load the configuration, raise the enable and spend one idle cycle in IDLE->ARMED.
  task automatic arm(input logic [1:0] mode, input logic [15:0] period, input logic [7:0] blen,
                     input logic [1:0] row, input logic [10:0] col, input logic [7:0] mask);
    i_corrupt_mode = mode;
    i_period       = period;
    i_burst_len    = blen;
    i_tgt_row      = row;
    i_tgt_col      = col;
    i_corrupt_mask = mask;
    i_corrupt_en   = 1'b1;
    idle_beat();
    check("busy_armed", o_busy, 1'b1);
  endtask

  task automatic disarm();
    i_corrupt_en = 1'b0;
    idle_beat();
    check("busy_idle", o_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst             = 1'b1;
    i_row_cnt         = '0;
    i_col_cnt         = '0;
    i_pyld_data       = 8'hFF;
    i_pyld_data_valid = 1'b1;
    i_frame_data_fas  = 1'b1;
    i_corrupt_en      = 1'b0;
    i_corrupt_mode    = '0;
    i_corrupt_mask    = '0;
    i_period          = '0;
    i_burst_len       = '0;
    i_tgt_row         = '0;
    i_tgt_col         = '0;
    i_fas_corrupt_en  = 1'b0;

    // Reset state: outputs held at zero even with active inputs.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", o_frame_data, 8'h00);
    check("rst_valid", o_frame_data_valid, 1'b0);
    check("rst_fas", o_frame_data_fas, 1'b0);
    check("rst_err", o_err_cnt, 16'd0);
    check("rst_busy", o_busy, 1'b0);
    @(negedge clk);
    i_rst             = 1'b0;
    i_pyld_data       = 8'h00;
    i_pyld_data_valid = 1'b0;
    i_frame_data_fas  = 1'b0;
    idle_beat();

    // T1: SINGLE at (1,5), mask 01 over A5; only the first frame is hit.
    arm(2'd0, 16'd0, 8'd0, 2'd1, 11'd5, 8'h01);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 16; c++)
          drive_beat(r[1:0], c[10:0], 8'hA5, 1'b1, 1'b0, (f == 0) && (r == 1) && (c == 5), 8'h01);
    check("t1_err", o_err_cnt, exp_err);
    check("t1_busy_done", o_busy, 1'b1);
    disarm();

    // T2: PERIODIC, period 4, mask FF, 40 eligible beats of 00.
    arm(2'd1, 16'd4, 8'd0, 2'd0, 11'd0, 8'hFF);
    for (int i = 0; i < 40; i++)
      drive_beat(2'd0, i[10:0], 8'h00, 1'b1, 1'b0, (i % 4) == 3, 8'hFF);
    check("t2_err", o_err_cnt, exp_err);
    disarm();

    // T3: PERIODIC, period 1, FAS beats F6 protected, then corruptible.
    i_fas_corrupt_en = 1'b0;
    arm(2'd1, 16'd1, 8'd0, 2'd0, 11'd0, 8'h0F);
    for (int i = 0; i < 8; i++)
      drive_beat(2'd0, i[10:0], (i % 2 == 0) ? 8'hF6 : 8'h00, 1'b1, i % 2 == 0, i % 2 != 0, 8'h0F);
    check("t3_err_prot", o_err_cnt, exp_err);
    i_fas_corrupt_en = 1'b1;
    for (int i = 0; i < 8; i++)
      drive_beat(2'd0, i[10:0], (i % 2 == 0) ? 8'hF6 : 8'h00, 1'b1, i % 2 == 0, 1'b1, 8'h0F);
    check("t3_err_open", o_err_cnt, exp_err);
    i_fas_corrupt_en = 1'b0;
    disarm();

    // T4: BURST len 3 at (0,10), a valid gap and a protected FAS beat inside
    // the burst; config changes after arming must be ignored.
    arm(2'd2, 16'd0, 8'd3, 2'd0, 11'd10, 8'h3C);
    i_burst_len = 8'd7;
    i_tgt_col   = 11'd0;
    for (int c = 0; c < 16; c++) begin
      drive_beat(2'd0, c[10:0], 8'h11, 1'b1, 1'b0, (c >= 10) && (c <= 12), 8'h3C);
      if (c == 10) drive_beat(2'd0, c[10:0], 8'h11, 1'b0, 1'b0, 1'b0, 8'h3C);
      if (c == 11) drive_beat(2'd0, c[10:0], 8'hF6, 1'b1, 1'b1, 1'b0, 8'h3C);
    end
    for (int c = 8; c < 13; c++)
      drive_beat(2'd0, c[10:0], 8'h22, 1'b1, 1'b0, 1'b0, 8'h3C);
    check("t4_err", o_err_cnt, exp_err);
    check("t4_busy_done", o_busy, 1'b1);
    disarm();

    // T5: PER_FRAME at (2,3) with LFSR mask over 4 frames.
    arm(2'd3, 16'd0, 8'd0, 2'd2, 11'd3, 8'h00);
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++)
          drive_beat(r[1:0], c[10:0], 8'h5A, 1'b1, 1'b0, (r == 2) && (c == 3), 8'h00);
    check("t5_err", o_err_cnt, exp_err);
    disarm();

    // T6a: BURST len 5 at (0,2); enable drops on the third burst beat.
    arm(2'd2, 16'd0, 8'd5, 2'd0, 11'd2, 8'h80);
    for (int c = 0; c < 4; c++)
      drive_beat(2'd0, c[10:0], 8'h00, 1'b1, 1'b0, c >= 2, 8'h80);
    i_corrupt_en = 1'b0;
    drive_beat(2'd0, 11'd4, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80);
    check("t6_busy_drop", o_busy, 1'b0);
    drive_beat(2'd0, 11'd5, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80);
    check("t6_err_abort", o_err_cnt, exp_err);

    // T6b: re-arm (fresh burst), then reset mid-burst.
    arm(2'd2, 16'd0, 8'd5, 2'd0, 11'd2, 8'h80);
    for (int c = 0; c < 4; c++)
      drive_beat(2'd0, c[10:0], 8'h00, 1'b1, 1'b0, c >= 2, 8'h80);
    check("t6_err_pre_rst", o_err_cnt, exp_err);
    @(negedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_rst_data", o_frame_data, 8'h00);
    check("t6_rst_valid", o_frame_data_valid, 1'b0);
    check("t6_rst_err", o_err_cnt, 16'd0);
    check("t6_rst_busy", o_busy, 1'b0);
    exp_err = 0;
    tb_lfsr = 16'hACE1;
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    // Enable is still high: first beat after release is clean, next one starts a burst.
    apply_beat(2'd0, 11'd2, 8'h77, 1'b1, 1'b0, 1'b0, 8'h80);
    collect_beat();
    drive_beat(2'd0, 11'd2, 8'h77, 1'b1, 1'b0, 1'b1, 8'h80);
    check("t6_err_after_rst", o_err_cnt, exp_err);
    disarm();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
